// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- word-only load/store unit for the MEM stage.
//
// Turns the decoded mem_rd/mem_wr controls into a req/gnt/rvalid transaction on
// the data-memory port. It stalls the pipeline while the access is in flight
// and hands load data to writeback as a one-cycle pulse.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   mem_rd_i, mem_wr_i            load / store request from the pipeline
//   addr_i, wdata_i, rd_addr_i    effective address, store data, load dest reg
//   data_req_o .. data_be_o       request side of the data-memory port
//   data_gnt_i, data_rvalid_i,
//   data_rdata_i                  grant / response side of the data-memory port
//   stall_o                       freezes IF/ID/EX/MEM while an access is open
//   wb_valid_o, wb_rdata_o,
//   wb_rd_o                       load result to writeback (1-cycle pulse)
//   err_o                         1-cycle pulse: misaligned, rd&wr, or timeout
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mem_rd_i,
    input  logic                mem_wr_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [4:0]          rd_addr_i,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    output logic [DATA_W/8-1:0] data_be_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic [DATA_W-1:0]   data_rdata_i,
    output logic                stall_o,
    output logic                wb_valid_o,
    output logic [DATA_W-1:0]   wb_rdata_o,
    output logic [4:0]          wb_rd_o,
    output logic                err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // Last REQ/WAIT cycle the access is allowed to occupy.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               we_q;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   tcnt_q;
    logic               load_done_q;   // DONE is for a completed load
    logic               timeout_q;     // DONE is for an aborted access
    logic [DATA_W-1:0]  wb_rdata_q;
    logic [4:0]         wb_rd_q;

    // Request decode in IDLE.
    logic access, both, aligned, accept, reject, tout;
    logic finish, abort;

    assign access  = mem_rd_i ^ mem_wr_i;
    assign both    = mem_rd_i & mem_wr_i;
    assign aligned = (addr_i[1:0] == 2'b00);
    assign accept  = (state_q == ST_IDLE) && access && aligned;
    assign reject  = (state_q == ST_IDLE) && (both || (access && !aligned));
    assign tout    = (tcnt_q == CNT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. finish = normal completion, abort = timeout.
    // NOTE: every combinational output gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                // A response in the grant cycle finishes immediately; a response
                // without a grant is not ours and is ignored.
                if (data_gnt_i && data_rvalid_i) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else if (tout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end else if (data_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_rvalid_i) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else if (tout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            // DONE never accepts: the pipeline still presents the instruction
            // that just finished, and taking it again would re-issue it.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, timeout counter and writeback capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            tcnt_q      <= '0;
            load_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            wb_rdata_q  <= '0;
            wb_rd_q     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= mem_wr_i;
                rd_q    <= rd_addr_i;
                tcnt_q  <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
                // Wraps only on the cycle that leaves for DONE, so harmless.
                tcnt_q <= tcnt_q + CNT_W'(1);
            end

            if (finish) begin
                load_done_q <= !we_q;
                timeout_q   <= 1'b0;
                if (!we_q) begin
                    wb_rdata_q <= data_rdata_i;
                    wb_rd_q    <= rd_q;
                end
            end else if (abort) begin
                load_done_q <= 1'b0;
                timeout_q   <= 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        data_req_o   = (state_q == ST_REQ);
        data_we_o    = (state_q == ST_REQ) && we_q;
        data_be_o    = (state_q == ST_REQ) ? {BE_W{1'b1}} : {BE_W{1'b0}};
        data_addr_o  = addr_q;
        data_wdata_o = wdata_q;
        stall_o      = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
        wb_valid_o   = (state_q == ST_DONE) && load_done_q;
        wb_rdata_o   = wb_rdata_q;
        wb_rd_o      = wb_rd_q;
        err_o        = reject || ((state_q == ST_DONE) && timeout_q);
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- directed self-checking bench for lsu_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are compared 4 time
// units after the rising edge, well before the next active edge.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        rd_addr;
    logic              data_req, data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_be;
    logic              data_gnt, data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              stall, wb_valid, err;
    logic [DATA_W-1:0] wb_rdata;
    logic [4:0]        wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .addr_i(addr), .wdata_i(wdata),
        .rd_addr_i(rd_addr),
        .data_req_o(data_req), .data_we_o(data_we), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_be_o(data_be),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .stall_o(stall), .wb_valid_o(wb_valid), .wb_rdata_o(wb_rdata), .wb_rd_o(wb_rd),
        .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        mem_rd = 0; mem_wr = 0; addr = '0; wdata = '0; rd_addr = '0;
        data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #4;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", data_req); end
        checks++; if (data_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", data_we); end
        checks++; if (data_be !== 4'h0) begin errors++; $display("FAIL rst_be: got %h exp 0", data_be); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", data_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL rst_wb_rdata: got %h exp 0", wb_rdata); end
        tick();
        rst_ni = 1'b1;
    endtask

    // Load 0x100 -> x5, gnt in first REQ cycle, rvalid two cycles after gnt.
    task automatic test_load();
        tick();
        mem_rd = 1; addr = 32'h100; rd_addr = 5'd5;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_accept_stall: got %b exp 1", stall); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ld_accept_req: got %b exp 0", data_req); end
        tick();                                   // REQ
        data_gnt = 1;
        settle();
        checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL ld_req: got %b exp 1", data_req); end
        checks++; if (data_addr !== 32'h100) begin errors++; $display("FAIL ld_addr: got %h exp 100", data_addr); end
        checks++; if (data_we !== 1'b0) begin errors++; $display("FAIL ld_we: got %b exp 0", data_we); end
        checks++; if (data_be !== 4'hF) begin errors++; $display("FAIL ld_be: got %h exp f", data_be); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_req_stall: got %b exp 1", stall); end
        tick();                                   // WAIT, gnt+1
        data_gnt = 0;
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ld_wait_req: got %b exp 0", data_req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_wait_stall: got %b exp 1", stall); end
        tick();                                   // WAIT, gnt+2: response
        data_rvalid = 1; data_rdata = 32'hDEADBEEF;
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wait_wbv: got %b exp 0", wb_valid); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_wait2_stall: got %b exp 1", stall); end
        tick();                                   // DONE, gnt+3
        data_rvalid = 0; data_rdata = '0;
        settle();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ld_wbv: got %b exp 1", wb_valid); end
        checks++; if (wb_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_wb_rdata: got %h exp deadbeef", wb_rdata); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL ld_wb_rd: got %0d exp 5", wb_rd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_done_stall: got %b exp 0", stall); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_done_err: got %b exp 0", err); end
        tick();                                   // IDLE
        idle_inputs();
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wbv_pulse: got %b exp 0", wb_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_idle_stall: got %b exp 0", stall); end
    endtask

    // Store 0x104 with grant held off for 3 REQ cycles.
    task automatic test_store();
        tick();
        mem_wr = 1; addr = 32'h104; wdata = 32'h12345678;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_accept_stall: got %b exp 1", stall); end
        for (int i = 0; i < 4; i++) begin
            tick();
            data_gnt = (i == 3);
            settle();
            checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL st_req[%0d]: got %b exp 1", i, data_req); end
            checks++; if (data_we !== 1'b1) begin errors++; $display("FAIL st_we[%0d]: got %b exp 1", i, data_we); end
            checks++; if (data_addr !== 32'h104) begin errors++; $display("FAIL st_addr[%0d]: got %h exp 104", i, data_addr); end
            checks++; if (data_wdata !== 32'h12345678) begin errors++; $display("FAIL st_wdata[%0d]: got %h exp 12345678", i, data_wdata); end
            checks++; if (data_be !== 4'hF) begin errors++; $display("FAIL st_be[%0d]: got %h exp f", i, data_be); end
        end
        tick();                                   // WAIT, ack arrives
        data_gnt = 0; data_rvalid = 1;
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL st_wait_req: got %b exp 0", data_req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_wait_stall: got %b exp 1", stall); end
        tick();                                   // DONE
        data_rvalid = 0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_done_stall: got %b exp 0", stall); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL st_done_wbv: got %b exp 0", wb_valid); end
        tick();
        idle_inputs();
    endtask

    // Misaligned load, then simultaneous rd & wr.
    task automatic test_illegal();
        tick();
        mem_rd = 1; addr = 32'h102; rd_addr = 5'd3;
        settle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b exp 1", err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", stall); end
        tick();
        mem_rd = 1; mem_wr = 1; addr = 32'h108;
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b exp 0", data_req); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b exp 1", err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rdwr_stall: got %b exp 0", stall); end
        tick();
        idle_inputs();
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rdwr_req: got %b exp 0", data_req); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rdwr_err_pulse: got %b exp 0", err); end
    endtask

    // No grant ever: request held TIMEOUT_CYC cycles, then aborted.
    task automatic test_timeout();
        tick();
        mem_rd = 1; addr = 32'h200; rd_addr = 5'd4;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            tick();
            settle();
            checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d]: got %b exp 1", i, data_req); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err[%0d]: got %b exp 0", i, err); end
        end
        tick();                                   // DONE after abort
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL to_done_req: got %b exp 0", data_req); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_done_err: got %b exp 1", err); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_done_wbv: got %b exp 0", wb_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_done_stall: got %b exp 0", stall); end
        tick();                                   // IDLE, late response
        idle_inputs();
        data_rvalid = 1; data_rdata = 32'hBAD0BAD0;
        settle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b exp 0", err); end
        tick();
        data_rvalid = 0;
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_late_wbv: got %b exp 0", wb_valid); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL to_late_req: got %b exp 0", data_req); end
    endtask

    // gnt&rvalid together; load then store presented back-to-back.
    task automatic test_back_to_back();
        tick();
        mem_rd = 1; addr = 32'h10; rd_addr = 5'd7;
        tick();                                   // REQ
        data_gnt = 1; data_rvalid = 1; data_rdata = 32'hCAFEF00D;
        settle();
        checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL b2b_ld_req: got %b exp 1", data_req); end
        tick();                                   // DONE, load still presented
        data_gnt = 0; data_rvalid = 0; data_rdata = '0;
        settle();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wbv: got %b exp 1", wb_valid); end
        checks++; if (wb_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rdata: got %h exp cafef00d", wb_rdata); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL b2b_rd: got %0d exp 7", wb_rd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b exp 0", stall); end
        tick();                                   // IDLE, store presented
        mem_rd = 0; mem_wr = 1; addr = 32'h20; wdata = 32'h55AA55AA;
        settle();
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL b2b_no_reissue: got %b exp 0", data_req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_st_accept: got %b exp 1", stall); end
        tick();                                   // REQ for the store
        data_gnt = 1; data_rvalid = 1;
        settle();
        checks++; if (data_we !== 1'b1) begin errors++; $display("FAIL b2b_st_we: got %b exp 1", data_we); end
        checks++; if (data_addr !== 32'h20) begin errors++; $display("FAIL b2b_st_addr: got %h exp 20", data_addr); end
        tick();                                   // DONE for the store
        data_gnt = 0; data_rvalid = 0;
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_st_wbv: got %b exp 0", wb_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_st_stall: got %b exp 0", stall); end
        tick();
        idle_inputs();
    endtask

    // Reset asserted while waiting for a load response.
    task automatic test_reset_mid_wait();
        tick();
        mem_rd = 1; addr = 32'h300; rd_addr = 5'd9;
        tick();                                   // REQ
        data_gnt = 1;
        tick();                                   // WAIT
        data_gnt = 0;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_wait_stall: got %b exp 1", stall); end
        #1;
        rst_ni = 0; mem_rd = 0;
        #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b exp 0", data_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_stall: got %b exp 0", stall); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL rw_addr: got %h exp 0", data_addr); end
        checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL rw_wb_rdata: got %h exp 0", wb_rdata); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rw_wb_rd: got %0d exp 0", wb_rd); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rw_wbv: got %b exp 0", wb_valid); end
        tick();
        rst_ni = 1; data_rvalid = 1; data_rdata = 32'h11112222;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_post_stall: got %b exp 0", stall); end
        tick();
        data_rvalid = 0;
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rw_post_wbv: got %b exp 0", wb_valid); end
        checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL rw_post_rdata: got %h exp 0", wb_rdata); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
